// File: rtl/risc_pkg.sv
// Shared types and widths for the 16-bit RISC pipeline MEM stage.
package risc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic                  valid;
    mem_op_t               op;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } mem_wb_t;

  // Read+write together is illegal; it resolves to a store so the read never fires.
  function automatic mem_op_t decode_mem_op(input logic rd_en, input logic wr_en);
    if (wr_en) return MEM_STORE;
    if (rd_en) return MEM_LOAD;
    return MEM_NONE;
  endfunction

endpackage

// File: rtl/mem_access_stage_pipe_reg.sv
// Generic pipeline register: 1-cycle latency, sync reset, hold freezes the
// contents (hold beats clear), clear loads zeros instead of i_d.
module pipe_reg #(
  parameter type T = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hold,
  input  logic i_clear,
  input  T     i_d,
  output T     o_q
);

  T r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_clear ? T'('0) : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM launches the data-memory access, MEM/WB captures load/ALU data
// one cycle later; stall holds both registers, flush squashes the EX/MEM entry.
module mem_access_stage
  import risc_pkg::*;
#(
  parameter int DATA_ROWS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_W-1:0]     dm_addr,
  output logic [DATA_W-1:0]     dm_write_data,
  output logic                  dm_write_en,
  output logic                  dm_read_en,
  input  logic [DATA_W-1:0]     dm_read_data,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  mem_fault,
  output logic [DATA_W-1:0]     fault_addr,
  output logic [CNT_W-1:0]      load_count,
  output logic [CNT_W-1:0]      store_count
);

  ex_mem_t w_ex_mem_d;
  ex_mem_t w_ex_mem_q;
  mem_wb_t w_mem_wb_d;
  mem_wb_t w_mem_wb_q;

  logic w_in_range;
  logic w_is_load;
  logic w_is_store;
  logic w_out_of_range;

  logic             r_mem_fault;
  logic [DATA_W-1:0] r_fault_addr;
  logic [CNT_W-1:0] r_load_count;
  logic [CNT_W-1:0] r_store_count;

  always_comb begin
    w_ex_mem_d            = '0;
    w_ex_mem_d.valid      = ex_valid;
    w_ex_mem_d.op         = decode_mem_op(ex_mem_read, ex_mem_write);
    w_ex_mem_d.alu_result = ex_alu_result;
    w_ex_mem_d.store_data = ex_store_data;
    w_ex_mem_d.reg_write  = ex_reg_write;
    w_ex_mem_d.rd         = ex_rd;
  end

  pipe_reg #(.T(ex_mem_t)) u_ex_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_hold  (stall),
    .i_clear (flush),
    .i_d     (w_ex_mem_d),
    .o_q     (w_ex_mem_q)
  );

  assign w_in_range     = 32'(w_ex_mem_q.alu_result) < 32'(DATA_ROWS);
  assign w_is_load      = w_ex_mem_q.valid && (w_ex_mem_q.op == MEM_LOAD);
  assign w_is_store     = w_ex_mem_q.valid && (w_ex_mem_q.op == MEM_STORE);
  assign w_out_of_range = (w_is_load || w_is_store) && !w_in_range;

  // Bus is parked at zero whenever the EX/MEM slot is empty.
  assign dm_addr       = w_ex_mem_q.valid ? w_ex_mem_q.alu_result : '0;
  assign dm_write_data = w_ex_mem_q.valid ? w_ex_mem_q.store_data : '0;
  assign dm_read_en    = w_is_load && w_in_range;
  assign dm_write_en   = w_is_store && w_in_range && !stall && !rst;

  always_comb begin
    w_mem_wb_d           = '0;
    w_mem_wb_d.valid     = w_ex_mem_q.valid;
    w_mem_wb_d.data      = (w_ex_mem_q.op == MEM_LOAD) ? dm_read_data : w_ex_mem_q.alu_result;
    w_mem_wb_d.rd        = w_ex_mem_q.rd;
    w_mem_wb_d.reg_write = w_ex_mem_q.valid && w_ex_mem_q.reg_write && !w_out_of_range;
  end

  pipe_reg #(.T(mem_wb_t)) u_mem_wb (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_hold  (stall),
    .i_clear (1'b0),
    .i_d     (w_mem_wb_d),
    .o_q     (w_mem_wb_q)
  );

  assign wb_valid     = w_mem_wb_q.valid;
  assign wb_data      = w_mem_wb_q.data;
  assign wb_rd        = w_mem_wb_q.rd;
  assign wb_reg_write = w_mem_wb_q.reg_write;

  // First out-of-range address is kept until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_fault  <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_out_of_range && !r_mem_fault) begin
      r_mem_fault  <= 1'b1;
      r_fault_addr <= w_ex_mem_q.alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_count  <= '0;
      r_store_count <= '0;
    end else if (!stall && w_in_range) begin
      if (w_is_load && (r_load_count != {CNT_W{1'b1}})) begin
        r_load_count <= r_load_count + CNT_W'(1);
      end
      if (w_is_store && (r_store_count != {CNT_W{1'b1}})) begin
        r_store_count <= r_store_count + CNT_W'(1);
      end
    end
  end

  assign mem_fault   = r_mem_fault;
  assign fault_addr  = r_fault_addr;
  assign load_count  = r_load_count;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural 256-word data memory.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [2:0]  ex_rd;
  logic        stall;
  logic        flush;
  logic [15:0] dm_addr;
  logic [15:0] dm_write_data;
  logic        dm_write_en;
  logic        dm_read_en;
  logic [15:0] dm_read_data;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_fault;
  logic [15:0] fault_addr;
  logic [15:0] load_count;
  logic [15:0] store_count;

  int vectors     = 0;
  int miscompares = 0;
  int wr_total    = 0;
  int wr_snap;

  logic [15:0] mem [0:255];

  mem_access_stage #(.DATA_ROWS(256), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .flush         (flush),
    .dm_addr       (dm_addr),
    .dm_write_data (dm_write_data),
    .dm_write_en   (dm_write_en),
    .dm_read_en    (dm_read_en),
    .dm_read_data  (dm_read_data),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_fault     (mem_fault),
    .fault_addr    (fault_addr),
    .load_count    (load_count),
    .store_count   (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_read_data = mem[dm_addr[7:0]];

  always @(posedge clk) begin
    if (dm_write_en) begin
      mem[dm_addr[7:0]] <= dm_write_data;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] sd,
                       input logic r, input logic w, input logic rw, input logic [2:0] rdst);
    ex_valid      = v;
    ex_alu_result = a;
    ex_store_data = sd;
    ex_mem_read   = r;
    ex_mem_write  = w;
    ex_reg_write  = rw;
    ex_rd         = rdst;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_load_cnt", load_count, 0);
    chk("rst_store_cnt", store_count, 0);
    chk("rst_dm_wen", dm_write_en, 0);
    chk("rst_dm_ren", dm_read_en, 0);
    chk("rst_dm_addr", dm_addr, 0);

    // Store 0xBEEF to 5, then load it back into r3.
    drive(1'b1, 16'd5, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b1, 16'd5, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3);
    #1;
    chk("st_wen", dm_write_en, 1);
    chk("st_ren", dm_read_en, 0);
    chk("st_addr", dm_addr, 5);
    chk("st_wdata", dm_write_data, 16'hBEEF);
    tick();
    idle();
    #1;
    chk("ld_wen", dm_write_en, 0);
    chk("ld_ren", dm_read_en, 1);
    chk("ld_addr", dm_addr, 5);
    chk("mem5", mem[5], 16'hBEEF);
    tick();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_wb_rd", wb_rd, 3);
    chk("ld_wb_reg_write", wb_reg_write, 1);
    chk("ld_store_cnt", store_count, 1);
    chk("ld_load_cnt", load_count, 1);

    // Plain ALU op passes its result through.
    drive(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6);
    tick();
    idle();
    #1;
    chk("alu_ren", dm_read_en, 0);
    chk("alu_wen", dm_write_en, 0);
    tick();
    chk("alu_wb_data", wb_data, 16'h1234);
    chk("alu_wb_rd", wb_rd, 6);
    chk("alu_wb_reg_write", wb_reg_write, 1);

    // Stalled store to 7: written once, in the release cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_snap = wr_total;
    drive(1'b1, 16'd7, 16'h0777, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 16'd9, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wen", dm_write_en, 0);
      chk("stall_addr", dm_addr, 7);
      tick();
    end
    stall = 1'b0;
    idle();
    #1;
    chk("release_wen", dm_write_en, 1);
    tick();
    chk("post_release_wen", dm_write_en, 0);
    chk("stall_writes", wr_total - wr_snap, 1);
    chk("mem7", mem[7], 16'h0777);
    chk("stall_store_cnt", store_count, 1);
    chk("stall_load_cnt", load_count, 0);

    // Out-of-range load at 300, then store at 400.
    drive(1'b1, 16'd300, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    drive(1'b1, 16'd400, 16'h5555, 1'b0, 1'b1, 1'b0, 3'd0);
    #1;
    chk("oor_ren", dm_read_en, 0);
    tick();
    idle();
    #1;
    chk("oor_wen", dm_write_en, 0);
    chk("oor_fault", mem_fault, 1);
    chk("oor_fault_addr", fault_addr, 300);
    chk("oor_wb_valid", wb_valid, 1);
    chk("oor_wb_reg_write", wb_reg_write, 0);
    tick();
    chk("oor_fault_sticky", mem_fault, 1);
    chk("oor_fault_addr_kept", fault_addr, 300);
    chk("oor_load_cnt", load_count, 0);
    chk("oor_store_cnt", store_count, 1);

    // Flush squashes a load.
    flush = 1'b1;
    drive(1'b1, 16'd5, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("flush_ren", dm_read_en, 0);
    chk("flush_addr", dm_addr, 0);
    tick();
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_wb_reg_write", wb_reg_write, 0);

    // Flush during stall is ignored; the held load survives.
    drive(1'b1, 16'd5, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    stall = 1'b1; flush = 1'b1;
    idle();
    #1;
    chk("sf_ren", dm_read_en, 1);
    tick();
    chk("sf_ren_held", dm_read_en, 1);
    chk("sf_addr_held", dm_addr, 5);
    chk("sf_wb_valid_held", wb_valid, 0);
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("sf_wb_valid", wb_valid, 1);
    chk("sf_wb_data", wb_data, 16'hBEEF);
    chk("sf_wb_rd", wb_rd, 4);
    chk("sf_wb_reg_write", wb_reg_write, 1);
    chk("sf_load_cnt", load_count, 1);

    // Reset during a store's access cycle blocks the write.
    drive(1'b1, 16'd10, 16'hAAAA, 1'b0, 1'b1, 1'b1, 3'd5);
    tick();
    wr_snap = wr_total;
    rst = 1'b1;
    idle();
    #1;
    chk("rstst_wen", dm_write_en, 0);
    chk("rstst_wdata", dm_write_data, 16'hAAAA);
    tick();
    rst = 1'b0;
    #1;
    chk("rstst_writes", wr_total - wr_snap, 0);
    chk("rstst_addr", dm_addr, 0);
    chk("rstst_wdata0", dm_write_data, 0);
    chk("rstst_wb_valid", wb_valid, 0);
    chk("rstst_wb_data", wb_data, 0);
    chk("rstst_wb_rd", wb_rd, 0);
    chk("rstst_fault", mem_fault, 0);
    chk("rstst_fault_addr", fault_addr, 0);
    chk("rstst_store_cnt", store_count, 0);
    chk("rstst_load_cnt", load_count, 0);

    // Load counter saturation.
    drive(1'b1, 16'd0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
    repeat (65535) tick();
    idle();
    tick(); tick();
    chk("sat_reach", load_count, 16'hFFFF);
    drive(1'b1, 16'd0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
    tick();
    idle();
    tick(); tick();
    chk("sat_hold", load_count, 16'hFFFF);
    chk("sat_store_cnt", store_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage of the 16-bit RISC core, between EX and WB; it is the sole driver of data_memory's addr/write_data/write_en/read_en and the sole consumer of its read_data.
- Holds the EX/MEM register, which launches the access, and the MEM/WB register, which captures the load or ALU result for writeback.
- Adds an out-of-range address fault and saturating load/store counters.

Parameters:
- DATA_ROWS, 256, number of 16-bit words in data memory; legal addresses are 0..DATA_ROWS-1.
- CNT_W, 16, width of the load/store counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX slot holds a real instruction
- ex_alu_result  in  16  effective address, or ALU result for non-memory ops
- ex_store_data  in  16  rs2 value for stores
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  3  destination register
- stall  in  1  hold both pipeline registers
- flush  in  1  squash the instruction entering EX/MEM
- dm_addr  out  16  to data_memory addr
- dm_write_data  out  16  to data_memory write_data
- dm_write_en  out  1  to data_memory write_en
- dm_read_en  out  1  to data_memory read_en
- dm_read_data  in  16  from data_memory read_data (combinational)
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_data  out  16  load data or ALU result
- wb_rd  out  3  destination register
- wb_reg_write  out  1  register-file write enable
- mem_fault  out  1  sticky out-of-range fault
- fault_addr  out  16  address of the first fault
- load_count  out  CNT_W  completed loads, saturating
- store_count  out  CNT_W  completed stores, saturating

Behaviour:
- Reset (rst high at a posedge): all EX/MEM and MEM/WB fields cleared, so wb_valid=0, wb_data=0, wb_rd=0, wb_reg_write=0. Also mem_fault=0, fault_addr=0, both counters=0.
- Outputs under reset: dm_* outputs are 0 whenever EX/MEM is invalid, including during and after reset.
- rst has priority over stall and flush. A reset mid-access blocks that cycle's store: dm_write_en is gated by !rst.
- EX/MEM capture: on a posedge with !stall, EX/MEM takes the ex_* inputs, with valid = ex_valid & !flush.
  - flush with stall: flush is ignored and the register holds.
- Access cycle: this is the cycle EX/MEM is valid.
  - in_range = mem_addr < DATA_ROWS.
  - dm_addr = mem_alu_result.
  - dm_write_data = mem_store_data.
  - dm_read_en = valid & mem_read & in_range.
  - dm_write_en = valid & mem_write & in_range & !stall & !rst. A stalled store is written exactly once, in its final non-stalled cycle.
  - mem_read and mem_write both set is illegal; it is treated as a store with the read suppressed.
- MEM/WB capture: on a posedge with !stall:
  - wb_valid <= mem_valid.
  - wb_data <= mem_read ? dm_read_data : mem_alu_result.
  - wb_rd <= mem_rd.
  - wb_reg_write <= mem_valid & mem_reg_write & !(mem_is_mem_op & !in_range).
  - Under stall, MEM/WB holds.
- Load-to-writeback latency: 1 cycle from the access cycle. Total EX to WB is 2 cycles.
- Fault: a valid load or store with !in_range suppresses the access and clears wb_reg_write.
  - If mem_fault is 0, it sets mem_fault=1 and fault_addr=address.
  - Later faults do not overwrite fault_addr. The flag clears only on rst.
- Counters: increment on a non-stalled access cycle of an in-range load or store. They saturate at 2^CNT_W-1 and do not wrap.
- Store followed by load to the same address: the store commits at the posedge, and the load in the next cycle reads the new value. No forwarding is needed.

Decomposition:
- Shared package risc_pkg: mem_op_t enum (MEM_NONE, MEM_LOAD, MEM_STORE); typedef ex_mem_t packed struct; typedef mem_wb_t packed struct; constants DATA_W=16 and REG_ADDR_W=3.
- One sub-module is natural: pipe_reg, a parameterized-type register with sync rst, a hold (stall) input and a clear (flush) input, instantiated twice.

Test Plan:
- Reset, then a store of 0xBEEF to address 5 followed by a load from address 5 → dm_write_en high for 1 cycle; two cycles later wb_data=0xBEEF, wb_rd matches, wb_reg_write=1; store_count=1, load_count=1.
- A store to address 7 with stall held for 3 cycles → dm_write_en asserts only in the release cycle; memory[7] written once; store_count=1.
- A load from address 300 (DATA_ROWS=256), then a store to 400 → dm_read_en=0 and dm_write_en=0; mem_fault=1 and fault_addr=300 (not 400); wb_reg_write=0; counters unchanged.
- A load with flush asserted on capture → no memory access, wb_valid=0; with flush and stall together, the held instruction is preserved.
- rst asserted in the access cycle of a store → no write; all outputs return to 0 at the next posedge.
- Force load_count to 0xFFFF via 65535 loads, then one more load → load_count stays 0xFFFF.
